pulse_meas: RTL and testbench
=============================

Name: pulse_meas

Overview:
- Pulse-width meter: measures, in clock cycles, how long a synchronous input stays high and reports the count with a valid/ack handshake.
- Receiving end for the team's counter-based pulse generators: a generator's `o` feeds `i` directly.
- Single clock domain; `i` must already be synchronous to `clk`.

Parameters:
- N, 4, width of the length counter and result; maximum measurable length is 2^N-1 cycles.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- i  input  1  pulse input, sampled every rising edge of clk.
- ack  input  1  consumer acknowledge for the current result.
- len  output  N  measured pulse length in cycles; held stable while valid=1.
- valid  output  1  result available.
- ovf  output  1  pulse exceeded 2^N-1 cycles; qualified by valid.
- busy  output  1  measurement in progress (state MEAS).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; len=0; valid=0; ovf=0; busy=0; cnt=0.
  - Previous-sample register prev=1, so a level already high when reset is released is never measured.
  - Reset has priority over all other inputs in every state, including mid-measurement.
- Rise detection: rise = i & ~prev. prev <= i every cycle outside reset.
- IDLE:
  - On rise: go to MEAS, cnt<=1.
  - Otherwise stay in IDLE.
- MEAS (busy=1):
  - i=1: cnt<=cnt+1, saturating at 2^N-1; a sat flag is set when an increment is attempted at 2^N-1.
  - i=0: len<=cnt, ovf<=sat, valid<=1, go to DONE, clear sat.
- DONE (valid=1):
  - len and ovf are held stable.
  - ack=0: stay in DONE. Any rise is ignored (not queued).
  - ack=1 with no rise: go to IDLE; valid<=0.
  - ack=1 with rise in the same cycle: go to MEAS, cnt<=1, valid<=0. Back-to-back pulses are therefore not lost when ack is immediate.
- ack outside DONE has no effect.
- Latency and timing:
  - An L-cycle pulse (i=1 sampled at L consecutive edges) gives valid=1 starting at the edge that samples the first i=0.
  - len=L for 1<=L<=2^N-1.
  - len=2^N-1 and ovf=1 for L>=2^N.
- Arithmetic: cnt is N bits, unsigned, and never wraps.
- ovf and len are not cleared on ack; they are don't-care while valid=0. They retain their value until the next result or reset.

Optional Feature:
- Macro: PULSE_MEAS_MISS_EN.
- Defined:
  - Adds output `miss` (1 bit), reset 0.
  - Set sticky on any rise ignored in DONE (ack=0).
  - Cleared only by rst.
- Undefined:
  - No `miss` port.
  - Ignored rises leave no trace.

Decomposition:
- Package pulse_meas_pkg holds:
  - typedef enum logic [1:0] {IDLE, MEAS, DONE} pulse_meas_state_t.
- One sub-module, pulse_cnt_sat#(N):
  - Synchronous saturating counter with inputs clk, rst, clr1 (load 1), inc.
  - Outputs cnt and sat.

Test Plan:
- Reset release with i held high for 5 cycles, then low: no valid, busy=0 throughout.
- N=4, one 12-cycle pulse from a generator that loads 4 and counts to wrap: valid=1 on the edge after the last high sample, len=12, ovf=0. Then ack=1 for one cycle: valid=0 next cycle, state IDLE.
- N=4, 20-cycle pulse: len=15, ovf=1. 1-cycle pulse: len=1, ovf=0.
- Back-to-back pulses:
  - 3-cycle pulse, result held with ack=0, then a 2-cycle pulse arrives: second pulse ignored, len stays 3. With PULSE_MEAS_MISS_EN, miss=1.
  - Repeat with ack asserted in the cycle of the second rise: len=2 reported next.
- rst asserted mid-MEAS at cnt=6: next cycle all outputs 0, and the still-high i is not measured until it goes low and rises again.
- ack pulsed in IDLE and MEAS: no state or output change. Measurement of a 7-cycle pulse still reports len=7.

Source files
------------

// File: rtl/pulse_meas_pkg.sv
// Shared types for the pulse-width meter.
package pulse_meas_pkg;

  typedef enum logic [1:0] {IDLE, MEAS, DONE} pulse_meas_state_t;

endpackage

// File: rtl/pulse_meas_if.sv
// Pulse input and result handshake bundle for pulse_meas.
// Optional `miss` signal is present when PULSE_MEAS_MISS_EN is defined.
// master: pulse source / result consumer.  slave: the meter.
interface pulse_meas_if #(parameter int N = 4);

  logic         i;
  logic         ack;
  logic [N-1:0] len;
  logic         valid;
  logic         ovf;
  logic         busy;
`ifdef PULSE_MEAS_MISS_EN
  logic         miss;

  modport master (output i, ack, input len, valid, ovf, busy, miss);
  modport slave  (input i, ack, output len, valid, ovf, busy, miss);
`else
  modport master (output i, ack, input len, valid, ovf, busy);
  modport slave  (input i, ack, output len, valid, ovf, busy);
`endif

endinterface

// File: rtl/pulse_cnt_sat.sv
// Saturating length counter: load-1, increment, and a flag recording
// that an increment was attempted at full scale.
module pulse_cnt_sat #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr1,
  input  logic         inc,
  output logic [N-1:0] cnt,
  output logic         sat
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  // Load-1 wins over increment; at full scale the count holds and sat sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr1) begin
      cnt <= CNT_ONE;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pulse_meas.sv
// Pulse-width meter: counts the cycles a synchronous input stays high and
// reports the length with a valid/ack handshake.
// Optional feature macro: PULSE_MEAS_MISS_EN (sticky `miss` on rises
// ignored while a result is pending).
//
// state | meaning
// IDLE  | waiting for a rising edge on i
// MEAS  | pulse in progress, counter running
// DONE  | result held, waiting for ack
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int N = 4
) (
  input logic      clk,
  input logic      rst,
  pulse_meas_if.slave bus
);

  pulse_meas_state_t state;
  logic              prev;
  logic              rise;
  logic [N-1:0]      len_q;
  logic              valid_q;
  logic              ovf_q;
  logic              busy_q;
  logic [N-1:0]      cnt;
  logic              sat;
  logic              clr1;
  logic              inc;
`ifdef PULSE_MEAS_MISS_EN
  logic              miss_q;
`endif

  assign rise = bus.i & ~prev;

  // Counter control: load 1 on every entry to MEAS and on exit (so sat is
  // clear for the next pulse); count while the pulse stays high.
  always_comb begin
    clr1 = 1'b0;
    inc  = 1'b0;
    case (state)
      IDLE:    clr1 = rise;
      MEAS: begin
        inc  = bus.i;
        clr1 = ~bus.i;
      end
      DONE:    clr1 = bus.ack & rise;
      default: clr1 = 1'b0;
    endcase
  end

  pulse_cnt_sat #(.N(N)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr1 (clr1),
    .inc  (inc),
    .cnt  (cnt),
    .sat  (sat)
  );

  // Sequencer with registered outputs; prev starts high so a level already
  // present at reset release is not taken as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prev    <= 1'b1;
      len_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PULSE_MEAS_MISS_EN
      miss_q  <= 1'b0;
`endif
    end else begin
      prev <= bus.i;
      case (state)
        IDLE: begin
          if (rise) begin
            state  <= MEAS;
            busy_q <= 1'b1;
          end
        end
        MEAS: begin
          if (!bus.i) begin
            len_q   <= cnt;
            ovf_q   <= sat;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.ack) begin
            valid_q <= 1'b0;
            if (rise) begin
              state  <= MEAS;
              busy_q <= 1'b1;
            end else begin
              state  <= IDLE;
            end
          end
`ifdef PULSE_MEAS_MISS_EN
          else if (rise) begin
            miss_q <= 1'b1;
          end
`endif
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.len   = len_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;
`ifdef PULSE_MEAS_MISS_EN
  assign bus.miss  = miss_q;
`endif

endmodule

// File: tb/tb_pulse_meas.sv
// Directed self-checking bench for pulse_meas (N=4).
// Covers PULSE_MEAS_MISS_EN when the macro is defined for the build.
module tb_pulse_meas;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_meas_if #(.N(4)) bus_if ();

  pulse_meas #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string tag, input int exp_len, input int exp_ovf);
    chk({tag, "_valid"}, 32'(bus_if.valid), 1);
    chk({tag, "_len"},   32'(bus_if.len),   32'(exp_len));
    chk({tag, "_ovf"},   32'(bus_if.ovf),   32'(exp_ovf));
    chk({tag, "_busy"},  32'(bus_if.busy),  0);
  endtask

  // Hold i high for l sampled edges, then sample one low.
  task automatic run_pulse(input string tag, input int l);
    bus_if.i = 1'b1;
    step();
    chk({tag, "_busy_start"}, 32'(bus_if.busy), 1);
    for (int k = 1; k < l; k++) step();
    chk({tag, "_no_early_valid"}, 32'(bus_if.valid), 0);
    bus_if.i = 1'b0;
    step();
  endtask

  task automatic do_ack(input string tag);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk({tag, "_ack_valid"}, 32'(bus_if.valid), 0);
    chk({tag, "_ack_busy"},  32'(bus_if.busy),  0);
  endtask

  initial begin
    rst        = 1'b1;
    bus_if.i   = 1'b1;
    bus_if.ack = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus_if.valid), 0);
    chk("rst_busy",  32'(bus_if.busy),  0);
    chk("rst_len",   32'(bus_if.len),   0);
    chk("rst_ovf",   32'(bus_if.ovf),   0);
`ifdef PULSE_MEAS_MISS_EN
    chk("rst_miss",  32'(bus_if.miss),  0);
`endif

    // Level high across reset release is never measured.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hi_at_rel_busy",  32'(bus_if.busy),  0);
      chk("hi_at_rel_valid", 32'(bus_if.valid), 0);
    end
    bus_if.i = 1'b0;
    step();
    chk("hi_at_rel_fall_valid", 32'(bus_if.valid), 0);
    chk("hi_at_rel_fall_busy",  32'(bus_if.busy),  0);
    step();

    // Generator loading 4 and counting to wrap on a 4-bit counter: 12 cycles.
    run_pulse("p12", 12);
    chk_result("p12", 12, 0);
    do_ack("p12");
    chk("p12_len_retained", 32'(bus_if.len), 12);
    step();
    chk("p12_idle_busy", 32'(bus_if.busy), 0);

    run_pulse("p20", 20);
    chk_result("p20", 15, 1);
    do_ack("p20");

    run_pulse("p15", 15);
    chk_result("p15", 15, 0);
    do_ack("p15");

    run_pulse("p16", 16);
    chk_result("p16", 15, 1);
    do_ack("p16");

    run_pulse("p1", 1);
    chk_result("p1", 1, 0);
    do_ack("p1");

    // Second pulse arriving while result held with ack=0 is dropped.
    run_pulse("b2b_a", 3);
    chk_result("b2b_a", 3, 0);
    step();
    bus_if.i = 1'b1;
    step();
    step();
    bus_if.i = 1'b0;
    step();
    chk_result("b2b_ignored", 3, 0);
`ifdef PULSE_MEAS_MISS_EN
    chk("b2b_miss", 32'(bus_if.miss), 1);
`endif
    do_ack("b2b_a");

    // Ack coinciding with the next rise starts the new measurement.
    run_pulse("b2b_b", 3);
    chk_result("b2b_b", 3, 0);
    step();
    bus_if.i   = 1'b1;
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("b2b_b_rise_ack_valid", 32'(bus_if.valid), 0);
    chk("b2b_b_rise_ack_busy",  32'(bus_if.busy),  1);
    step();
    bus_if.i = 1'b0;
    step();
    chk_result("b2b_b_second", 2, 0);
    do_ack("b2b_b_second");

    // Reset mid-measurement at cnt=6.
    bus_if.i = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("mid_busy_before_rst", 32'(bus_if.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus_if.valid), 0);
    chk("mid_rst_busy",  32'(bus_if.busy),  0);
    chk("mid_rst_len",   32'(bus_if.len),   0);
    chk("mid_rst_ovf",   32'(bus_if.ovf),   0);
`ifdef PULSE_MEAS_MISS_EN
    chk("mid_rst_miss",  32'(bus_if.miss),  0);
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_still_high_busy", 32'(bus_if.busy), 0);
    end
    bus_if.i = 1'b0;
    step();
    chk("mid_rst_fall_valid", 32'(bus_if.valid), 0);

    // Ack in IDLE and in MEAS has no effect.
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("ack_idle_valid", 32'(bus_if.valid), 0);
    chk("ack_idle_busy",  32'(bus_if.busy),  0);
    chk("ack_idle_len",   32'(bus_if.len),   0);
    bus_if.i = 1'b1;
    step();
    chk("p7_busy_start", 32'(bus_if.busy), 1);
    step();
    step();
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("ack_meas_busy",  32'(bus_if.busy),  1);
    chk("ack_meas_valid", 32'(bus_if.valid), 0);
    step();
    step();
    step();
    bus_if.i = 1'b0;
    step();
    chk_result("p7", 7, 0);
    do_ack("p7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
